// File: rtl/sh7034_rst_ctrl_pkg.sv
// Shared types for the SH7034 reset controller: FSM states, reset sources, cause codes
// and the decode from (state, source) to the registered reset outputs.
package SH7034_PKG;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXT  = 2'd1,
    ST_WRES = 2'd2,
    ST_HOLD = 2'd3
  } RSTC_state_t;

  typedef enum logic [1:0] {
    SRC_EXT = 2'd0,
    SRC_WPO = 2'd1,
    SRC_WMR = 2'd2
  } RES_SRC_t;

  typedef logic [1:0] RES_CAUSE_t;

  localparam RES_CAUSE_t RES_CAUSE_EXT = 2'b00;
  localparam RES_CAUSE_t RES_CAUSE_WPO = 2'b01;
  localparam RES_CAUSE_t RES_CAUSE_WMR = 2'b10;

  localparam int DIV_W = 13;

  typedef struct packed {
    logic wdt_res_n;
    logic periph_res_n;
    logic cpu_res_n;
    logic cpu_res_type;
  } res_out_t;

  // A WDT power-on reset leaves the WDT itself running so RSTCSR.WOVF survives;
  // a manual reset touches the CPU only.
  function automatic res_out_t decode_res(RSTC_state_t st, RES_SRC_t src);
    res_out_t r;
    r.wdt_res_n    = 1'b1;
    r.periph_res_n = 1'b1;
    r.cpu_res_n    = 1'b1;
    r.cpu_res_type = 1'b0;
    if (st == ST_RUN) begin
      r.cpu_res_n = 1'b1;
    end else if (st == ST_EXT || src == SRC_EXT) begin
      r.wdt_res_n    = 1'b0;
      r.periph_res_n = 1'b0;
      r.cpu_res_n    = 1'b0;
    end else if (src == SRC_WPO) begin
      r.periph_res_n = 1'b0;
      r.cpu_res_n    = 1'b0;
    end else begin
      r.cpu_res_n    = 1'b0;
      r.cpu_res_type = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sh7034_rst_ctrl_if.sv
// Reset/strobe bundle between the reset controller (master) and the WDT and
// peripherals (slave).
interface sh7034_rst_ctrl_if;
  import SH7034_PKG::*;

  logic       WDT_PRES;
  logic       WDT_MRES;
  logic       WDT_RES_N;
  logic       PERIPH_RES_N;
  logic       CPU_RES_N;
  logic       CPU_RES_TYPE;
  RES_CAUSE_t RES_CAUSE;
  logic       CLK2_CE;
  logic       CLK4_CE;
  logic       CLK8_CE;
  logic       CLK64_CE;
  logic       CLK128_CE;
  logic       CLK256_CE;
  logic       CLK512_CE;
  logic       CLK1024_CE;
  logic       CLK4096_CE;
  logic       CLK8192_CE;

  modport master (
    input  WDT_PRES, WDT_MRES,
    output WDT_RES_N, PERIPH_RES_N, CPU_RES_N, CPU_RES_TYPE, RES_CAUSE,
    output CLK2_CE, CLK4_CE, CLK8_CE, CLK64_CE, CLK128_CE, CLK256_CE,
    output CLK512_CE, CLK1024_CE, CLK4096_CE, CLK8192_CE
  );

  modport slave (
    output WDT_PRES, WDT_MRES,
    input  WDT_RES_N, PERIPH_RES_N, CPU_RES_N, CPU_RES_TYPE, RES_CAUSE,
    input  CLK2_CE, CLK4_CE, CLK8_CE, CLK64_CE, CLK128_CE, CLK256_CE,
    input  CLK512_CE, CLK1024_CE, CLK4096_CE, CLK8192_CE
  );

endinterface

// File: rtl/sh7034_rst_ctrl_prescaler.sv
// phi/n clock-enable prescaler: 13-bit divider advanced on CE_R, held at zero by clr,
// with each strobe decoded from the low bits being all ones.
module sh7034_prescaler
  import SH7034_PKG::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic CE_R,
  input  logic clr,
  output logic CLK2_CE,
  output logic CLK4_CE,
  output logic CLK8_CE,
  output logic CLK64_CE,
  output logic CLK128_CE,
  output logic CLK256_CE,
  output logic CLK512_CE,
  output logic CLK1024_CE,
  output logic CLK4096_CE,
  output logic CLK8192_CE
);

  logic [DIV_W-1:0] div;
  logic             strobe_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (CE_R) begin
      div <= div + 1'b1;
    end
  end

  // The clear comes from a registered reset, so gate the strobes too: the divider
  // still holds its old count during the first cleared cycle.
  assign strobe_en  = CE_R & ~clr;

  assign CLK2_CE    = strobe_en & div[0];
  assign CLK4_CE    = strobe_en & (&div[1:0]);
  assign CLK8_CE    = strobe_en & (&div[2:0]);
  assign CLK64_CE   = strobe_en & (&div[5:0]);
  assign CLK128_CE  = strobe_en & (&div[6:0]);
  assign CLK256_CE  = strobe_en & (&div[7:0]);
  assign CLK512_CE  = strobe_en & (&div[8:0]);
  assign CLK1024_CE = strobe_en & (&div[9:0]);
  assign CLK4096_CE = strobe_en & (&div[11:0]);
  assign CLK8192_CE = strobe_en & (&div[12:0]);

endmodule

// File: rtl/sh7034_rst_ctrl.sv
// SH7034 reset controller: RES_N synchroniser, reset sequencing FSM and prescaler.
// Define SH7034_MANUAL_RESET_EN to honour WDT manual-reset requests.
module sh7034_rst_ctrl
  import SH7034_PKG::*;
#(
  parameter int RES_HOLD = 16  // CE_R cycles of hold after release, 1..255
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CE_R,
  input  logic                     RES_N,
  sh7034_rst_ctrl_if.master        rst_bus
);

  localparam logic [7:0] HOLD_INIT = 8'(RES_HOLD - 1);

  logic        res_meta;
  logic        res_s;
  logic        mres_req;

  RSTC_state_t state_q, state_d;
  RES_SRC_t    src_q,   src_d;
  logic [7:0]  cnt_q,   cnt_d;
  RES_CAUSE_t  cause_q, cause_d;
  res_out_t    res_q,   res_d;

`ifdef SH7034_MANUAL_RESET_EN
  assign mres_req = rst_bus.WDT_MRES;
`else
  logic [1:0] unused_mres;
  assign mres_req    = 1'b0;
  assign unused_mres = {rst_bus.WDT_MRES, res_q.cpu_res_type};
`endif

  // NOTE: the synchroniser resets to 1 (pin inactive) so leaving RST_N goes straight
  // into the hold countdown instead of detouring through EXT for two cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_meta <= 1'b1;
      res_s    <= 1'b1;
    end else begin
      res_meta <= RES_N;
      res_s    <= res_meta;
    end
  end

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (CE_R) begin
      unique case (state_q)
        ST_RUN: begin
          if (!res_s) begin
            state_d = ST_EXT;
            src_d   = SRC_EXT;
            cause_d = RES_CAUSE_EXT;
          end else if (rst_bus.WDT_PRES) begin
            state_d = ST_WRES;
            src_d   = SRC_WPO;
            cause_d = RES_CAUSE_WPO;
          end else if (mres_req) begin
            state_d = ST_WRES;
            src_d   = SRC_WMR;
            cause_d = RES_CAUSE_WMR;
          end
        end
        ST_EXT: begin
          if (res_s) begin
            state_d = ST_HOLD;
            src_d   = SRC_EXT;
            cnt_d   = HOLD_INIT;
          end
        end
        ST_WRES: begin
          if (!res_s) begin
            state_d = ST_EXT;
            src_d   = SRC_EXT;
            cause_d = RES_CAUSE_EXT;
          end else if (!rst_bus.WDT_PRES && !mres_req) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_INIT;
          end
        end
        ST_HOLD: begin
          // WDT requests are deliberately not looked at while holding.
          if (!res_s) begin
            state_d = ST_EXT;
            src_d   = SRC_EXT;
            cause_d = RES_CAUSE_EXT;
          end else if (cnt_q == 8'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      endcase
    end
    res_d = decode_res(state_d, src_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_HOLD;
      src_q   <= SRC_EXT;
      cnt_q   <= HOLD_INIT;
      cause_q <= RES_CAUSE_EXT;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      res_q   <= res_d;
    end
  end

  assign rst_bus.WDT_RES_N    = res_q.wdt_res_n;
  assign rst_bus.PERIPH_RES_N = res_q.periph_res_n;
  assign rst_bus.CPU_RES_N    = res_q.cpu_res_n;
  assign rst_bus.RES_CAUSE    = cause_q;
`ifdef SH7034_MANUAL_RESET_EN
  assign rst_bus.CPU_RES_TYPE = res_q.cpu_res_type;
`else
  assign rst_bus.CPU_RES_TYPE = 1'b0;
`endif

  sh7034_prescaler u_prescaler (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CE_R       (CE_R),
    .clr        (~res_q.wdt_res_n),
    .CLK2_CE    (rst_bus.CLK2_CE),
    .CLK4_CE    (rst_bus.CLK4_CE),
    .CLK8_CE    (rst_bus.CLK8_CE),
    .CLK64_CE   (rst_bus.CLK64_CE),
    .CLK128_CE  (rst_bus.CLK128_CE),
    .CLK256_CE  (rst_bus.CLK256_CE),
    .CLK512_CE  (rst_bus.CLK512_CE),
    .CLK1024_CE (rst_bus.CLK1024_CE),
    .CLK4096_CE (rst_bus.CLK4096_CE),
    .CLK8192_CE (rst_bus.CLK8192_CE)
  );

endmodule

// File: tb/tb_sh7034_rst_ctrl.sv
// Bench for sh7034_rst_ctrl (RES_HOLD=4): directed vector table, pulse and prescaler
// sequences, then random stimulus against a behavioural model.
module tb_sh7034_rst_ctrl;
  import SH7034_PKG::*;

  localparam int HOLD = 4;
  localparam int DIVS[10] = '{2, 4, 8, 64, 128, 256, 512, 1024, 4096, 8192};

`ifdef SH7034_MANUAL_RESET_EN
  localparam bit         MAN_EN = 1'b1;
  localparam logic [3:0] R_MRES = 4'b1101;
  localparam logic [1:0] C_MRES = 2'b10;
`else
  localparam bit         MAN_EN = 1'b0;
  localparam logic [3:0] R_MRES = 4'b1110;
  localparam logic [1:0] C_MRES = 2'b01;
`endif

  // {WDT_RES_N, PERIPH_RES_N, CPU_RES_N, CPU_RES_TYPE}
  localparam logic [3:0] R_ALL0 = 4'b0000;
  localparam logic [3:0] R_ALL1 = 4'b1110;
  localparam logic [3:0] R_WPO  = 4'b1000;

  logic CLK = 1'b0;
  logic RST_N, CE_R, RES_N;

  sh7034_rst_ctrl_if bus ();

  sh7034_rst_ctrl #(.RES_HOLD(HOLD)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CE_R    (CE_R),
    .RES_N   (RES_N),
    .rst_bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // {resets(4), cause(2), CLK2, CLK4, CLK8, CLK64, CLK128, CLK256, CLK512, CLK1024, CLK4096, CLK8192}
  function automatic logic [15:0] obs();
    return {bus.WDT_RES_N, bus.PERIPH_RES_N, bus.CPU_RES_N, bus.CPU_RES_TYPE, bus.RES_CAUSE,
            bus.CLK2_CE, bus.CLK4_CE, bus.CLK8_CE, bus.CLK64_CE, bus.CLK128_CE,
            bus.CLK256_CE, bus.CLK512_CE, bus.CLK1024_CE, bus.CLK4096_CE, bus.CLK8192_CE};
  endfunction

  typedef struct {
    logic       res_n;
    logic       pres;
    logic       mres;
    logic [7:0] exp;   // {resets, cause, CLK2, CLK4}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic p, logic m, logic [3:0] rs, logic [1:0] c,
                              logic [1:0] st);
    vec_t v;
    v.res_n = r;
    v.pres  = p;
    v.mres  = m;
    v.exp   = {rs, c, st};
    tbl.push_back(v);
  endfunction

  // One row per CE_R edge after RST_N release (edge 1 first).
  function automatic void build_table();
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);  // e1..e3 power-on hold
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL1, 2'b00, 2'b00);  // e4 release, divider at 0
    add(1, 0, 0, R_ALL1, 2'b00, 2'b10);  // e5 first CLK2
    add(1, 1, 0, R_WPO,  2'b01, 2'b00);  // e6 WDT power-on asserts at once
    add(1, 1, 0, R_WPO,  2'b01, 2'b11);
    add(1, 1, 0, R_WPO,  2'b01, 2'b00);
    add(1, 0, 0, R_WPO,  2'b01, 2'b10);  // e9 hold entry
    add(1, 0, 0, R_WPO,  2'b01, 2'b00);
    add(1, 0, 0, R_WPO,  2'b01, 2'b11);
    add(1, 0, 0, R_WPO,  2'b01, 2'b00);
    add(1, 0, 0, R_ALL1, 2'b01, 2'b10);  // e13 release
    add(1, 0, 1, R_MRES, C_MRES, 2'b00); // e14 manual request
    add(1, 0, 0, R_MRES, C_MRES, 2'b11);
    add(1, 0, 0, R_MRES, C_MRES, 2'b00);
    add(1, 0, 0, R_MRES, C_MRES, 2'b10);
    add(1, 0, 0, R_MRES, C_MRES, 2'b00);
    add(1, 0, 0, R_ALL1, C_MRES, 2'b11); // e19
    add(1, 1, 0, R_WPO,  2'b01, 2'b00);  // e20
    add(1, 0, 0, R_WPO,  2'b01, 2'b10);  // e21 hold entry
    add(0, 0, 0, R_WPO,  2'b01, 2'b00);  // e22 pin falls, still synchronising
    add(0, 0, 0, R_WPO,  2'b01, 2'b11);
    add(0, 0, 0, R_ALL0, 2'b00, 2'b00);  // e24 external pre-empts the hold
    add(0, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);  // e26 pin rises
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);  // e28 hold entry
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL0, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL1, 2'b00, 2'b00);  // e32 release, divider restarted
    add(1, 0, 0, R_ALL1, 2'b00, 2'b10);
    add(1, 0, 0, R_ALL1, 2'b00, 2'b00);
    add(1, 0, 0, R_ALL1, 2'b00, 2'b11);
  endfunction

  // Behavioural model: which reset is in effect, whether its source is still
  // asserted, and how many CE_R edges remain until release.
  int m_kind;    // 0 none, 1 external, 2 WDT power-on, 3 WDT manual
  bit m_active;
  int m_left;
  int m_cause;
  int m_ticks;   // CE_R edges since the WDT reset last released, mod 8192
  bit m_s1, m_s2;

  function automatic void model_reset();
    m_kind   = 1;
    m_active = 1'b0;
    m_left   = HOLD;
    m_cause  = 0;
    m_ticks  = 0;
    m_s1     = 1'b1;
    m_s2     = 1'b1;
  endfunction

  function automatic void model_step();
    bit wdt_running;
    bit mres_eff;
    wdt_running = (m_kind != 1);
    mres_eff    = MAN_EN && bus.WDT_MRES;
    if (CE_R) begin
      if (!m_s2) begin
        m_kind   = 1;
        m_active = 1'b1;
        m_cause  = 0;
      end else if (m_active) begin
        if (m_kind == 1 || (!bus.WDT_PRES && !mres_eff)) begin
          m_active = 1'b0;
          m_left   = HOLD;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_kind = 0;
      end else if (bus.WDT_PRES) begin
        m_kind   = 2;
        m_active = 1'b1;
        m_cause  = 1;
      end else if (mres_eff) begin
        m_kind   = 3;
        m_active = 1'b1;
        m_cause  = 2;
      end
    end
    if (!wdt_running)  m_ticks = 0;
    else if (CE_R)     m_ticks = (m_ticks + 1) % 8192;
    m_s2 = m_s1;
    m_s1 = RES_N;
  endfunction

  function automatic logic [15:0] model_obs();
    logic [3:0] r;
    logic [9:0] s;
    case (m_kind)
      0:       r = R_ALL1;
      1:       r = R_ALL0;
      2:       r = R_WPO;
      default: r = 4'b1101;
    endcase
    for (int k = 0; k < 10; k++)
      s[9-k] = CE_R && (m_kind != 1) && (((m_ticks + 1) % DIVS[k]) == 0);
    return {r, m_cause[1:0], s};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] o;
    logic [5:0]  o_fall;
    int fall_at, rise_at, first_c2, rel;
    int c2, c512, c4096, c8192, first2, first8192;

    RST_N = 1'b0; CE_R = 1'b1; RES_N = 1'b1;
    bus.WDT_PRES = 1'b0; bus.WDT_MRES = 1'b0;
    build_table();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    o = obs();
    check("reset_state", o, 16'h0000);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      RES_N        = tbl[i].res_n;
      bus.WDT_PRES = tbl[i].pres;
      bus.WDT_MRES = tbl[i].mres;
      @(posedge CLK);
      @(negedge CLK);
      o = obs();
      check($sformatf("vec_e%0d", i + 1), o[15:8], tbl[i].exp);
    end

    // RES_N low for 10 CLK while running.
    fall_at = -1; rise_at = -1; first_c2 = -1; o_fall = 6'h3f;
    for (int i = 1; i <= 30; i++) begin
      RES_N = (i <= 10) ? 1'b0 : 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      o = obs();
      if (fall_at < 0 && !bus.CPU_RES_N) begin
        fall_at = i;
        o_fall  = o[15:10];
      end
      if (fall_at >= 0 && rise_at < 0 && bus.CPU_RES_N) rise_at = i;
      if (rise_at >= 0 && first_c2 < 0 && bus.CLK2_CE) first_c2 = i;
    end
    check("pulse_fall_edge", fall_at, 3);
    check("pulse_fall_outputs", o_fall, 6'b000000);
    check("pulse_rise_edge", rise_at, 17);
    check("pulse_first_clk2", first_c2, 18);

    // Fresh power-on, then count strobes over 16384 CE_R edges.
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    rel = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.WDT_RES_N) begin
        rel = i;
        break;
      end
    end
    check("boot_release_edge", rel, HOLD);
    c2 = 0; c512 = 0; c4096 = 0; c8192 = 0; first2 = -1; first8192 = -1;
    for (int s = 0; s < 16384; s++) begin
      o = obs();
      if (o[9]) begin c2++;    if (first2 < 0)    first2 = s;    end
      if (o[3]) c512++;
      if (o[1]) c4096++;
      if (o[0]) begin c8192++; if (first8192 < 0) first8192 = s; end
      @(posedge CLK);
      @(negedge CLK);
    end
    check("boot_first_clk2", first2, 1);
    check("first_clk8192", first8192, 8191);
    check("count_clk2", c2, 8192);
    check("count_clk512", c512, 32);
    check("count_clk4096", c4096, 4);
    check("count_clk8192", c8192, 2);

    // Random stimulus against the model.
    RST_N = 1'b0; RES_N = 1'b1; CE_R = 1'b1;
    bus.WDT_PRES = 1'b0; bus.WDT_MRES = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
    o = obs();
    check("rand_reset", o, model_obs());
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) RES_N = ~RES_N;
      if ($urandom_range(0, 11) == 0) bus.WDT_PRES = ~bus.WDT_PRES;
      if ($urandom_range(0, 11) == 0) bus.WDT_MRES = ~bus.WDT_MRES;
      CE_R = ($urandom_range(0, 3) != 0);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      o = obs();
      check($sformatf("rand_%0d", i), o, model_obs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
